// File: rtl/output_weight_update_pkg.sv
// Shared state encoding and default geometry for the output-layer weight update block.
package output_weight_update_pkg;

  localparam int DEF_N_W      = 4;
  localparam int DEF_W_W      = 8;
  localparam int DEF_H_W      = 10;
  localparam int DEF_X_W      = 4;
  localparam int DEF_F_W      = 23;
  localparam int DEF_LR_SHIFT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/output_grad_calc.sv
// Combinational per-slot update: w_new = w - ((2*(x - final)*h) >>> LR_SHIFT).
// OUTPUT_WU_SAT_EN selects clamping of w_new; otherwise it wraps to W_W bits.
module output_grad_calc
  import output_weight_update_pkg::*;
#(
  parameter int W_W      = DEF_W_W,
  parameter int H_W      = DEF_H_W,
  parameter int X_W      = DEF_X_W,
  parameter int F_W      = DEF_F_W,
  parameter int LR_SHIFT = DEF_LR_SHIFT
) (
  input  logic [X_W-1:0] x_i,
  input  logic [F_W-1:0] final_i,
  input  logic [H_W-1:0] hidden_i,
  input  logic [W_W-1:0] w_i,
  output logic [W_W-1:0] w_new_o,
  output logic           sat_o
);

  // Wide enough that err*h*2 and the final subtraction never lose bits.
  localparam int A_W = F_W + H_W + 3;

  localparam logic signed [A_W-1:0] W_MAX = {{(A_W-W_W+1){1'b0}}, {(W_W-1){1'b1}}};
  localparam logic signed [A_W-1:0] W_MIN = {{(A_W-W_W+1){1'b1}}, {(W_W-1){1'b0}}};

  logic signed [A_W-1:0] err;
  logic signed [A_W-1:0] grad;
  logic signed [A_W-1:0] delta;
  logic signed [A_W-1:0] w_full;

  function automatic logic signed [A_W-1:0] floor_shift(input logic signed [A_W-1:0] v);
    return v >>> LR_SHIFT;
  endfunction

  function automatic logic fits_w(input logic signed [A_W-1:0] v);
    return (v <= W_MAX) && (v >= W_MIN);
  endfunction

`ifdef OUTPUT_WU_SAT_EN
  function automatic logic [W_W-1:0] clamp_w(input logic signed [A_W-1:0] v);
    if (v > W_MAX)      return W_MAX[W_W-1:0];
    else if (v < W_MIN) return W_MIN[W_W-1:0];
    else                return v[W_W-1:0];
  endfunction
`endif

  always_comb begin
    err     = signed'(A_W'(x_i)) - signed'({{(A_W-F_W){final_i[F_W-1]}}, final_i});
    grad    = (err * signed'(A_W'(hidden_i))) <<< 1;
    delta   = floor_shift(grad);
    w_full  = signed'({{(A_W-W_W){w_i[W_W-1]}}, w_i}) - delta;
    sat_o   = !fits_w(w_full);
`ifdef OUTPUT_WU_SAT_EN
    w_new_o = clamp_w(w_full);
`else
    w_new_o = w_full[W_W-1:0];
`endif
  end

endmodule

// File: rtl/output_weight_update.sv
// Sequential backward-pass weight update: one output weight per CALC cycle.
// Build option OUTPUT_WU_SAT_EN (clamp instead of wrap) is handled in output_grad_calc.
module output_weight_update
  import output_weight_update_pkg::*;
#(
  parameter int N_W      = DEF_N_W,
  parameter int W_W      = DEF_W_W,
  parameter int H_W      = DEF_H_W,
  parameter int X_W      = DEF_X_W,
  parameter int F_W      = DEF_F_W,
  parameter int LR_SHIFT = DEF_LR_SHIFT,
  localparam int IDX_W   = (N_W > 1) ? $clog2(N_W) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               clear_i,
  input  logic [X_W-1:0]     x_i,
  input  logic [F_W-1:0]     final_i,
  input  logic [N_W*H_W-1:0] hidden_i,
  input  logic [N_W*W_W-1:0] w_i,
  output logic [N_W*W_W-1:0] w_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               sat_o
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [F_W-1:0]     final_q, final_d;
  logic [N_W*H_W-1:0] hidden_q, hidden_d;
  logic [N_W*W_W-1:0] w_q, w_d;
  logic               sat_q, sat_d;

  logic [H_W-1:0]     hid_sel;
  logic [W_W-1:0]     w_sel;
  logic [W_W-1:0]     w_new;
  logic               slot_sat;

  // One shared arithmetic unit, steered by idx to the slot being updated.
  assign hid_sel = hidden_q[idx_q*H_W +: H_W];
  assign w_sel   = w_q[idx_q*W_W +: W_W];

  output_grad_calc #(
    .W_W      (W_W),
    .H_W      (H_W),
    .X_W      (X_W),
    .F_W      (F_W),
    .LR_SHIFT (LR_SHIFT)
  ) u_grad_calc (
    .x_i      (x_q),
    .final_i  (final_q),
    .hidden_i (hid_sel),
    .w_i      (w_sel),
    .w_new_o  (w_new),
    .sat_o    (slot_sat)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    x_d      = x_q;
    final_d  = final_q;
    hidden_d = hidden_q;
    w_d      = w_q;
    sat_d    = sat_q;

    if (clear_i) begin
      state_d = IDLE;
      idx_d   = '0;
      w_d     = '0;
      sat_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            x_d      = x_i;
            final_d  = final_i;
            hidden_d = hidden_i;
            w_d      = w_i;
            sat_d    = 1'b0;
            idx_d    = '0;
            state_d  = CALC;
          end
        end
        CALC: begin
          w_d[idx_q*W_W +: W_W] = w_new;
          sat_d = sat_q | slot_sat;
          if (idx_q == IDX_W'(N_W-1)) begin
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o = (state_q == CALC);
    done_o = (state_q == DONE);
    idx_o  = (state_q == CALC) ? idx_q : '0;
    w_o    = w_q;
    sat_o  = sat_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      x_q      <= '0;
      final_q  <= '0;
      hidden_q <= '0;
      w_q      <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      x_q      <= x_d;
      final_q  <= final_d;
      hidden_q <= hidden_d;
      w_q      <= w_d;
      sat_q    <= sat_d;
    end
  end

endmodule

// File: tb/tb_output_weight_update.sv
// Directed-vector bench for output_weight_update (default geometry, N_W=4).
module tb_output_weight_update;

  logic        clk;
  logic        rst;
  logic        start;
  logic        clear;
  logic [3:0]  x;
  logic [22:0] fin;
  logic [39:0] hid;
  logic [31:0] w;
  logic [31:0] w_out;
  logic        busy;
  logic        done;
  logic [1:0]  idx;
  logic        sat;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int base;

`ifdef OUTPUT_WU_SAT_EN
  localparam logic [31:0] EXP_SAT_W   = 32'h1122337F;
  localparam logic [31:0] EXP_CLAMP_W = 32'h00800000;
`else
  localparam logic [31:0] EXP_SAT_W   = 32'h11223364;
  localparam logic [31:0] EXP_CLAMP_W = 32'h00820000;
`endif

  output_weight_update dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .clear_i  (clear),
    .x_i      (x),
    .final_i  (fin),
    .hidden_i (hid),
    .w_i      (w),
    .w_o      (w_out),
    .busy_o   (busy),
    .done_o   (done),
    .idx_o    (idx),
    .sat_o    (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns in cycle 1 of the pass (first CALC cycle).
  task automatic start_pass(input logic [3:0] xv, input logic [22:0] fv,
                            input logic [39:0] hv, input logic [31:0] wv);
    x = xv; fin = fv; hid = hv; w = wv;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; clear = 1'b0; x = '0; fin = '0; hid = '0; w = '0;
    tick(2);
    vectors++; if (w_out !== 32'h0) begin miscompares++; $display("FAIL reset_w: got %h want %h", w_out, 32'h0); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (idx !== 2'd0) begin miscompares++; $display("FAIL reset_idx: got %0d want 0", idx); end
    vectors++; if (sat !== 1'b0) begin miscompares++; $display("FAIL reset_sat: got %b want 0", sat); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    base = done_cnt;
    start_pass(4'd5, 23'd3, {10'd7, 10'd0, 10'd8, 10'd16}, 32'h9C32FD0A);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_c1: got %b want 1", busy); end
    vectors++; if (idx !== 2'd0) begin miscompares++; $display("FAIL basic_idx_c1: got %0d want 0", idx); end
    vectors++; if (w_out !== 32'h9C32FD0A) begin miscompares++; $display("FAIL basic_latch_w: got %h want %h", w_out, 32'h9C32FD0A); end
    tick();
    vectors++; if (w_out !== 32'h9C32FD06) begin miscompares++; $display("FAIL basic_slot0: got %h want %h", w_out, 32'h9C32FD06); end
    vectors++; if (idx !== 2'd1) begin miscompares++; $display("FAIL basic_idx_c2: got %0d want 1", idx); end
    tick();
    vectors++; if (w_out !== 32'h9C32FB06) begin miscompares++; $display("FAIL basic_slot1: got %h want %h", w_out, 32'h9C32FB06); end
    vectors++; if (idx !== 2'd2) begin miscompares++; $display("FAIL basic_idx_c3: got %0d want 2", idx); end
    tick();
    vectors++; if (idx !== 2'd3) begin miscompares++; $display("FAIL basic_idx_c4: got %0d want 3", idx); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_early_done: got %b want 0", done); end
    tick();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL basic_done_c5: got %b want 1", done); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_c5: got %b want 0", busy); end
    vectors++; if (idx !== 2'd0) begin miscompares++; $display("FAIL basic_idx_c5: got %0d want 0", idx); end
    vectors++; if (w_out !== 32'h9B32FB06) begin miscompares++; $display("FAIL basic_final_w: got %h want %h", w_out, 32'h9B32FB06); end
    vectors++; if (sat !== 1'b0) begin miscompares++; $display("FAIL basic_sat: got %b want 0", sat); end
    tick();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_c6: got %b want 0", done); end
    vectors++; if (done_cnt - base !== 1) begin miscompares++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - base); end
  endtask

  task automatic test_sat;
    start_pass(4'd3, 23'd5, {30'd0, 10'd1023}, 32'h11223364);
    tick();
    vectors++; if (w_out !== EXP_SAT_W) begin miscompares++; $display("FAIL sat_slot0: got %h want %h", w_out, EXP_SAT_W); end
    vectors++; if (sat !== 1'b1) begin miscompares++; $display("FAIL sat_flag_c2: got %b want 1", sat); end
    tick(3);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL sat_done: got %b want 1", done); end
    vectors++; if (sat !== 1'b1) begin miscompares++; $display("FAIL sat_sticky: got %b want 1", sat); end
    vectors++; if (w_out !== EXP_SAT_W) begin miscompares++; $display("FAIL sat_final_w: got %h want %h", w_out, EXP_SAT_W); end
    tick();
  endtask

  task automatic test_clamp_low;
    start_pass(4'd15, 23'd0, {10'd0, 10'd1023, 20'd0}, 32'h00000000);
    vectors++; if (sat !== 1'b0) begin miscompares++; $display("FAIL clamp_sat_cleared: got %b want 0", sat); end
    tick(2);
    vectors++; if (sat !== 1'b0) begin miscompares++; $display("FAIL clamp_sat_c3: got %b want 0", sat); end
    tick();
    vectors++; if (sat !== 1'b1) begin miscompares++; $display("FAIL clamp_sat_c4: got %b want 1", sat); end
    vectors++; if (w_out !== EXP_CLAMP_W) begin miscompares++; $display("FAIL clamp_slot2: got %h want %h", w_out, EXP_CLAMP_W); end
    tick(2);
  endtask

  task automatic test_neg_final;
    start_pass(4'd0, 23'h7FFFFF, {20'd0, 10'd1, 10'd32}, 32'h00008000);
    tick(4);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL negf_done: got %b want 1", done); end
    vectors++; if (w_out !== 32'h000080FC) begin miscompares++; $display("FAIL negf_w: got %h want %h", w_out, 32'h000080FC); end
    vectors++; if (sat !== 1'b0) begin miscompares++; $display("FAIL negf_sat: got %b want 0", sat); end
    tick();
  endtask

  task automatic test_zero_err;
    start_pass(4'd0, 23'd0, {4{10'd1023}}, 32'h807F01FF);
    tick(4);
    vectors++; if (w_out !== 32'h807F01FF) begin miscompares++; $display("FAIL zero_w: got %h want %h", w_out, 32'h807F01FF); end
    vectors++; if (sat !== 1'b0) begin miscompares++; $display("FAIL zero_sat: got %b want 0", sat); end
    tick();
  endtask

  task automatic test_back_to_back;
    base = done_cnt;
    x = 4'd1; fin = 23'd0; hid = {30'd0, 10'd16}; w = 32'h44332200;
    start = 1'b1;
    tick();
    x = 4'd15; w = 32'h55555555; hid = {4{10'd1023}};
    tick();
    vectors++; if (idx !== 2'd1) begin miscompares++; $display("FAIL hold_no_restart: got idx %0d want 1", idx); end
    vectors++; if (w_out !== 32'h443322FE) begin miscompares++; $display("FAIL hold_no_relatch: got %h want %h", w_out, 32'h443322FE); end
    tick(3);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL hold_done: got %b want 1", done); end
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL hold_start_in_done: got busy %b want 0", busy); end
    vectors++; if (done_cnt - base !== 1) begin miscompares++; $display("FAIL hold_one_done: got %0d want 1", done_cnt - base); end
    vectors++; if (w_out !== 32'h443322FE) begin miscompares++; $display("FAIL hold_final_w: got %h want %h", w_out, 32'h443322FE); end
    x = 4'd0; fin = 23'd0; w = 32'h11111111;
    tick();
    start = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept: got busy %b want 1", busy); end
    vectors++; if (idx !== 2'd0) begin miscompares++; $display("FAIL b2b_idx: got %0d want 0", idx); end
    tick(4);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL b2b_done: got %b want 1", done); end
    vectors++; if (w_out !== 32'h11111111) begin miscompares++; $display("FAIL b2b_w: got %h want %h", w_out, 32'h11111111); end
    tick();
    vectors++; if (done_cnt - base !== 2) begin miscompares++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - base); end
  endtask

  task automatic test_clear;
    base = done_cnt;
    start_pass(4'd3, 23'd5, {30'd0, 10'd1023}, 32'h11223364);
    tick(2);
    vectors++; if (idx !== 2'd2) begin miscompares++; $display("FAIL clear_pre_idx: got %0d want 2", idx); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    vectors++; if (w_out !== 32'h0) begin miscompares++; $display("FAIL clear_w: got %h want %h", w_out, 32'h0); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL clear_busy: got %b want 0", busy); end
    vectors++; if (idx !== 2'd0) begin miscompares++; $display("FAIL clear_idx: got %0d want 0", idx); end
    vectors++; if (sat !== 1'b0) begin miscompares++; $display("FAIL clear_sat: got %b want 0", sat); end
    tick(4);
    vectors++; if (done_cnt - base !== 0) begin miscompares++; $display("FAIL clear_no_done: got %0d want 0", done_cnt - base); end
    w = 32'hA5A5A5A5; x = 4'd1; hid = {4{10'd1}};
    clear = 1'b1; start = 1'b1;
    tick();
    clear = 1'b0; start = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL clear_prio_busy: got %b want 0", busy); end
    vectors++; if (w_out !== 32'h0) begin miscompares++; $display("FAIL clear_prio_w: got %h want %h", w_out, 32'h0); end
    tick();
  endtask

  task automatic test_async_reset;
    base = done_cnt;
    start_pass(4'd3, 23'd5, {30'd0, 10'd1023}, 32'h11223364);
    tick(2);
    #3;
    rst = 1'b1;
    #1;
    vectors++; if (w_out !== 32'h0) begin miscompares++; $display("FAIL areset_w: got %h want %h", w_out, 32'h0); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL areset_busy: got %b want 0", busy); end
    vectors++; if (idx !== 2'd0) begin miscompares++; $display("FAIL areset_idx: got %0d want 0", idx); end
    vectors++; if (sat !== 1'b0) begin miscompares++; $display("FAIL areset_sat: got %b want 0", sat); end
    #2;
    rst = 1'b0;
    tick(5);
    vectors++; if (done_cnt - base !== 0) begin miscompares++; $display("FAIL areset_no_done: got %0d want 0", done_cnt - base); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL areset_idle: got busy %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sat();
    test_clamp_low();
    test_neg_final();
    test_zero_err();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
